// File: rtl/four_bit_cla_high_prompt.sv
// Registered 4-bit carry-lookahead adder with group propagate/generate outputs for cascading.
// Define CLA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module four_bit_cla_high_prompt (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       grp_p,
  output logic       grp_g,
`ifdef CLA_OVERFLOW_EN
  output logic       ovf,
`endif
  output logic       out_valid
);

  logic [3:0] p, g;
  logic [4:0] c;
  logic [3:0] sum_d, sum_q;
  logic       grp_p_d, grp_p_q;
  logic       grp_g_d, grp_g_q;
  logic       cout_q;
  logic       valid_q;

  // Every carry is a flat sum-of-products of p/g/cin so no carry waits on its neighbour.
  always_comb begin
    p       = a ^ b;
    g       = a & b;
    c[0]    = cin;
    c[1]    = g[0] | (p[0] & cin);
    c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
              (p[3] & p[2] & p[1] & p[0] & cin);
    sum_d   = p ^ c[3:0];
    grp_p_d = &p;
    grp_g_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= 4'h0;
      cout_q  <= 1'b0;
      grp_p_q <= 1'b0;
      grp_g_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q   <= sum_d;
        cout_q  <= c[4];
        grp_p_q <= grp_p_d;
        grp_g_q <= grp_g_d;
      end
    end
  end

`ifdef CLA_OVERFLOW_EN
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from the carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (in_valid) begin
      ovf_q <= c[4] ^ c[3];
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign grp_p     = grp_p_q;
  assign grp_g     = grp_g_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_four_bit_cla_high_prompt.sv
// Self-checking bench for four_bit_cla_high_prompt: directed, exhaustive and random stimulus
// against an arithmetic reference model.
module tb_four_bit_cla_high_prompt;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic       cin;
  logic [3:0] sum;
  logic       cout, grp_p, grp_g, out_valid;
`ifdef CLA_OVERFLOW_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  four_bit_cla_high_prompt dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .grp_p     (grp_p),
    .grp_g     (grp_g),
`ifdef CLA_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {out_valid, cout, sum[3:0], grp_p, grp_g} from plain integer arithmetic.
  function automatic logic [7:0] model(input logic v, input int ai, input int bi, input int ci);
    int   total;
    logic gp, gg;
    total = ai + bi + ci;
    gg    = (ai + bi) >= 16;                 // carries out regardless of cin
    gp    = (ai + bi) == 15;                 // carries out exactly when cin does
    return {v, total[4], total[3:0], gp, gg};
  endfunction

  function automatic logic [7:0] observed();
    return {out_valid, cout, sum, grp_p, grp_g};
  endfunction

  task automatic drive(input logic v, input logic [3:0] ai, input logic [3:0] bi, input logic ci);
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (observed() !== 8'h00) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h required 00", i, observed());
      end
    end
    rst = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    n_checks++;
    if (observed() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h required 00", observed());
    end
  endtask

  task automatic test_directed();
    logic [3:0] av [6] = '{4'b0101, 4'b1111, 4'b1111, 4'b1000, 4'b0110, 4'b1010};
    logic [3:0] bv [6] = '{4'b0011, 4'b0001, 4'b1111, 4'b1000, 4'b1001, 4'b0101};
    logic       cv [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] want [6] = '{5'b0_1001, 5'b1_0000, 5'b1_1111, 5'b1_0001, 5'b0_1111, 5'b1_0000};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, av[i], bv[i], cv[i]);
      tick();
      n_checks++;
      if ({out_valid, cout, sum} !== {1'b1, want[i]}) begin
        n_fail++;
        $display("FAIL directed %0d: got v=%b cout=%b sum=%b required v=1 cout=%b sum=%b",
                 i, out_valid, cout, sum, want[i][4], want[i][3:0]);
      end
    end
  endtask

  task automatic test_full_propagate();
    drive(1'b1, 4'b1010, 4'b0101, 1'b1);
    tick();
    n_checks++;
    if ({cout, sum, grp_p, grp_g} !== 7'b1_0000_10) begin
      n_fail++;
      $display("FAIL propagate_cin1: got cout=%b sum=%b gp=%b gg=%b required 1 0000 1 0",
               cout, sum, grp_p, grp_g);
    end
    drive(1'b1, 4'b1010, 4'b0101, 1'b0);
    tick();
    n_checks++;
    if ({cout, sum, grp_p, grp_g} !== 7'b0_1111_10) begin
      n_fail++;
      $display("FAIL propagate_cin0: got cout=%b sum=%b gp=%b gg=%b required 0 1111 1 0",
               cout, sum, grp_p, grp_g);
    end
  endtask

  task automatic test_exhaustive();
    int errs = 0;
    for (int i = 0; i < 512; i++) begin
      logic [7:0] exp;
      drive(1'b1, i[3:0], i[7:4], i[8]);
      tick();
      exp = model(1'b1, i[3:0], i[7:4], i[8]);
      if (observed() !== exp || cout !== (grp_g | (grp_p & i[8]))) begin
        errs++;
        if (errs <= 8)
          $display("FAIL exhaustive a=%h b=%h cin=%b: got %h required %h",
                   i[3:0], i[7:4], i[8], observed(), exp);
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL exhaustive_total: got %0d bad results required 0", errs);
    end
  endtask

  task automatic test_hold();
    logic [7:0] exp;
    drive(1'b1, 4'b0111, 4'b0111, 1'b0);
    tick();
    drive(1'b0, 4'hA, 4'h3, 1'b1);
    exp = model(1'b1, 7, 7, 0);
    n_checks++;
    if (observed() !== exp) begin
      n_fail++;
      $display("FAIL hold_load: got %h required %h", observed(), exp);
    end
    exp[7] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (observed() !== exp) begin
        n_fail++;
        $display("FAIL hold_cycle %0d: got %h required %h", i, observed(), exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp;
    drive(1'b1, 4'h9, 4'h9, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b1, 4'h4, 4'h5, 1'b0);
    tick();
    n_checks++;
    if (observed() !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_discard: got %h required 00", observed());
    end
    rst = 1'b0;
    drive(1'b1, 4'h6, 4'hC, 1'b1);
    tick();
    exp = model(1'b1, 6, 12, 1);
    n_checks++;
    if (observed() !== exp) begin
      n_fail++;
      $display("FAIL mid_reset_first: got %h required %h", observed(), exp);
    end
  endtask

  task automatic test_random();
    logic [7:0] held;
    int         errs = 0;
    held = observed();  // seeded from the last checked state, valid bit ignored below
    held = model(1'b0, 6, 12, 1);
    for (int i = 0; i < 300; i++) begin
      logic v;
      int   ra, rb, rc;
      v  = ($urandom_range(0, 3) != 0);
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      rc = $urandom_range(0, 1);
      drive(v, ra[3:0], rb[3:0], rc[0]);
      tick();
      if (v) held = model(1'b1, ra, rb, rc);
      else   held[7] = 1'b0;
      if (observed() !== held) begin
        errs++;
        if (errs <= 8)
          $display("FAIL random step %0d: got %h required %h", i, observed(), held);
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL random_total: got %0d bad results required 0", errs);
    end
  endtask

`ifdef CLA_OVERFLOW_EN
  task automatic test_overflow();
    logic [3:0] av [3] = '{4'b0111, 4'b1000, 4'b0011};
    logic [3:0] bv [3] = '{4'b0001, 4'b1000, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      int   sa, sb, ss;
      logic want;
      sa   = av[i][3] ? int'(av[i]) - 16 : int'(av[i]);
      sb   = bv[i][3] ? int'(bv[i]) - 16 : int'(bv[i]);
      ss   = sa + sb;
      want = (ss > 7) || (ss < -8);
      drive(1'b1, av[i], bv[i], 1'b0);
      tick();
      n_checks++;
      if (ovf !== want) begin
        n_fail++;
        $display("FAIL overflow %0d: got ovf=%b required %b", i, ovf, want);
      end
    end
    n_checks++;
    if ({cout, sum} !== 5'b0_0101) begin
      n_fail++;
      $display("FAIL overflow_last_sum: got %b required 00101", {cout, sum});
    end
    rst = 1'b1;
    drive(1'b1, 4'b0111, 4'b0001, 1'b0);
    tick();
    rst = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_reset: got ovf=%b required 0", ovf);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    test_reset();
    test_directed();
    test_full_propagate();
    test_exhaustive();
    test_hold();
    test_mid_reset();
    test_random();
`ifdef CLA_OVERFLOW_EN
    test_overflow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/four_bit_cla_high_prompt.md
Name: four_bit_cla_high_prompt

Overview:
- 4-bit carry-lookahead adder: computes a + b + cin with all carries flattened from generate/propagate terms; no ripple chain.
- Result is registered, with 1-cycle latency and a valid qualifier.
- Exports group propagate/generate so a parent can cascade 4-bit blocks under a second-level lookahead unit.

Parameters:
- none (width fixed at 4 bits)

Ports:
- clk        input   1  rising-edge clock
- rst        input   1  synchronous reset, active-high
- in_valid   input   1  qualifies a, b and cin this cycle
- a          input   4  operand A, unsigned
- b          input   4  operand B, unsigned
- cin        input   1  carry in
- sum        output  4  registered sum bits
- cout       output  1  registered carry out of bit 3
- grp_p      output  1  registered group propagate (p3&p2&p1&p0)
- grp_g      output  1  registered group generate (independent of cin)
- out_valid  output  1  high when sum/cout/grp_* hold a new result

Interface notes:
- One clock; reset is synchronous and active-high.

Behaviour:
- Per bit: p_i = a_i ^ b_i and g_i = a_i & b_i; c0 = cin.
- Carries are flattened sum-of-products; no c_i is computed from c_(i-1):
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = g3 | p3g2 | p3p2g1 | p3p2p1g0 | p3p2p1p0c0
- sum_i = p_i ^ c_i; cout = c4.
- Group terms:
  - grp_p = p3p2p1p0
  - grp_g = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - invariant: cout == grp_g | (grp_p & cin).
- Arithmetic: {cout,sum} == a + b + cin, range 0..31. Wrap-around: a sum of 16 or more sets cout, and sum holds the low 4 bits.
- Timing, on each rising clk:
  - rst=1: sum=0, cout=0, grp_p=0, grp_g=0, out_valid=0 (plus ovf=0 when enabled). Reset has priority over in_valid.
  - rst=0 and in_valid=1: all result registers load the combinational result; out_valid<=1.
  - rst=0 and in_valid=0: result registers hold their previous value; out_valid<=0.
- Latency is exactly 1 cycle from the in_valid edge to out_valid. Back-to-back in_valid gives a result every cycle; there is no backpressure.
- Reset asserted mid-stream discards the in-flight result. The first output after reset release appears 1 cycle after the first in_valid.
- Outputs never change except at a clk edge.

Optional Feature:
- Macro: CLA_OVERFLOW_EN
- Defined:
  - adds output port ovf (1 bit, registered) = c4 ^ c3, the two's-complement signed overflow flag.
  - ovf follows the same load, hold and reset rules as sum (reset value 0).
- Undefined: port ovf is absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=4'hF, b=4'hF -> sum=0, cout=0, grp_p=0, grp_g=0, out_valid=0 throughout.
- Directed vectors, in_valid=1, results checked 1 cycle later:
  - a=0101, b=0011, cin=1 -> sum=1001, cout=0
  - a=1111, b=0001, cin=0 -> sum=0000, cout=1
  - a=1111, b=1111, cin=1 -> sum=1111, cout=1
  - a=1000, b=1000, cin=1 -> sum=0001, cout=1
  - a=0110, b=1001, cin=0 -> sum=1111, cout=0
- Full-propagate chain: a=1010, b=0101, cin=1 -> sum=0000, cout=1, grp_p=1, grp_g=0. Same operands with cin=0 -> sum=1111, cout=0.
- Exhaustive: all 512 (a,b,cin) triples streamed back-to-back. Each cycle's result must equal {cout,sum}=a+b+cin from the previous cycle, and cout must equal grp_g|(grp_p&cin).
- Hold and valid: in_valid pulsed for one cycle with a=0111, b=0111, cin=0, then low for 3 cycles -> sum=1110, cout=0 held for all 3 cycles; out_valid high for exactly 1 cycle.
- CLA_OVERFLOW_EN defined:
  - a=0111, b=0001, cin=0 -> ovf=1
  - a=1000, b=1000, cin=0 -> ovf=1, sum=0000, cout=1
  - a=0011, b=0010, cin=0 -> ovf=0
